cdma_gold_xcvr: RTL and testbench

- Parametrised multi-channel CDMA transceiver core: one shared Gold-code generator (LFSR A) plus one LFSR B per channel gives one Gold code per channel.
- TX path spreads one data bit per channel per symbol over SF chips.
- RX path despreads a single received chip stream against every channel code using integrate-and-dump correlators with hard decisions.
- Sits between the symbol source/sink and the chip-rate line interface; chip rate is set by a clock-enable strobe.

---
 rtl/cdma_pkg.sv | 24 ++
 rtl/cdma_lfsr.sv | 35 +++
 rtl/cdma_gold_xcvr.sv | 150 +++++++++++++++
 tb/tb_cdma_gold_xcvr.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdma_pkg.sv
// Shared constants and helpers for the multi-channel CDMA Gold-code transceiver.
package cdma_pkg;

  localparam logic [4:0] TAPS_A_DEFAULT = 5'b11110;
  localparam logic [4:0] TAPS_B_DEFAULT = 5'b10010;

  // One Fibonacci shift: the parity of the tapped bits enters at the LSB.
  // Widths are carried in 32 bits so one function serves every LFSR size.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input logic [31:0] mask,
                                            input int          width);
    logic [31:0] nxt;
    logic [31:0] keep;
    nxt  = {state[30:0], ^(state & mask)};
    keep = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return nxt & keep;
  endfunction

  // Signed correlator width able to hold +/-sf without saturation.
  function automatic int acc_width(input int sf);
    return $clog2(sf + 1) + 1;
  endfunction

endpackage

// File: rtl/cdma_lfsr.sv
// Seedable LFSR that advances one step per chip strobe and exposes its MSB.
// An all-zero seed would lock the register, so it is replaced by 1.
module cdma_lfsr
  import cdma_pkg::*;
#(
  parameter int             N    = 5,
  parameter logic [N-1:0]   TAPS = N'(TAPS_A_DEFAULT)
) (
  input  logic         clk_i,
  input  logic         set_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [N-1:0] seed_i,
  output logic         msb_o
);

  logic [N-1:0] state_q;
  logic [N-1:0] seed_fix;

  assign seed_fix = (seed_i == '0) ? N'(1) : seed_i;

  // Seed on reset or realignment, otherwise shift once per chip strobe.
  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      state_q <= seed_fix;
    end else if (load_i) begin
      state_q <= seed_fix;
    end else if (en_i) begin
      state_q <= N'(lfsr_step(32'(state_q), 32'(TAPS), N));
    end
  end

  assign msb_o = state_q[N-1];

endmodule

// File: rtl/cdma_gold_xcvr.sv
// Multi-channel CDMA transceiver: one shared LFSR A plus one LFSR B per
// channel forms a Gold code per channel. TX spreads one bit per symbol over
// SF chips; RX despreads a single chip stream with integrate-and-dump
// correlators and hard decisions.
module cdma_gold_xcvr
  import cdma_pkg::*;
#(
  parameter int                N_LFSR = 5,
  parameter logic [N_LFSR-1:0] TAPS_A = N_LFSR'(TAPS_A_DEFAULT),
  parameter logic [N_LFSR-1:0] TAPS_B = N_LFSR'(TAPS_B_DEFAULT),
  parameter int                N_CH   = 2,
  parameter int                SF     = 31,
  parameter int                ACC_W  = acc_width(SF)
) (
  input  logic                     clk_i,
  input  logic                     set_i,
  input  logic                     en_i,
  input  logic                     sync_i,
  input  logic [N_LFSR-1:0]        seed_a_i,
  input  logic [N_CH*N_LFSR-1:0]   seed_b_i,
  input  logic [N_CH-1:0]          data_i,
  output logic                     sym_strobe_o,
  output logic [N_CH-1:0]          gold_o,
  output logic [N_CH-1:0]          tx_chip_o,
  input  logic                     rx_chip_i,
  output logic [N_CH-1:0]          rx_data_o,
  output logic [N_CH*ACC_W-1:0]    rx_corr_o,
  output logic                     rx_valid_o,
  output logic                     seed_zero_o
);

  localparam int               CNT_W    = $clog2(SF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sym_last;
  logic             a_msb;
  logic [N_CH-1:0]  b_msb;
  logic [N_CH-1:0]  tx_data_q;
  logic             rx_valid_q;
  logic             seed_zero;

  assign sym_last     = (cnt_q == CNT_LAST);
  assign sym_strobe_o = en_i && sym_last;

  cdma_lfsr #(
    .N    (N_LFSR),
    .TAPS (TAPS_A)
  ) u_lfsr_a (
    .clk_i  (clk_i),
    .set_i  (set_i),
    .en_i   (en_i),
    .load_i (sync_i),
    .seed_i (seed_a_i),
    .msb_o  (a_msb)
  );

  assign gold_o    = {N_CH{a_msb}} ^ b_msb;
  assign tx_chip_o = tx_data_q ^ gold_o;

  // Chip counter within a symbol; LFSRs free-run across the wrap.
  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      cnt_q <= '0;
    end else if (sync_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= sym_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // TX symbol latch: the new bit spreads the next SF chips; sync keeps it.
  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      tx_data_q <= '0;
    end else if (!sync_i && en_i && sym_last) begin
      tx_data_q <= data_i;
    end
  end

  // Decision-valid pulse, one clock after the last chip of a symbol.
  always_ff @(posedge clk_i or negedge set_i) begin
    if (!set_i) begin
      rx_valid_q <= 1'b0;
    end else if (sync_i) begin
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= en_i && sym_last;
    end
  end

  assign rx_valid_o = rx_valid_q;

  // Flag any all-zero seed; the LFSRs substitute 1 on their own.
  always_comb begin
    seed_zero = (seed_a_i == '0);
    for (int k = 0; k < N_CH; k++) begin
      if (seed_b_i[k*N_LFSR +: N_LFSR] == '0) begin
        seed_zero = 1'b1;
      end
    end
  end

  assign seed_zero_o = seed_zero;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] corr_q;
    logic                    dec_q;

    cdma_lfsr #(
      .N    (N_LFSR),
      .TAPS (TAPS_B)
    ) u_lfsr_b (
      .clk_i  (clk_i),
      .set_i  (set_i),
      .en_i   (en_i),
      .load_i (sync_i),
      .seed_i (seed_b_i[k*N_LFSR +: N_LFSR]),
      .msb_o  (b_msb[k])
    );

    assign acc_next = (rx_chip_i ^ gold_o[k]) ? acc_q + ACC_W'(1)
                                              : acc_q - ACC_W'(1);

    // Integrate-and-dump: dump on the last chip, a zero sum decides 0.
    always_ff @(posedge clk_i or negedge set_i) begin
      if (!set_i) begin
        acc_q  <= '0;
        corr_q <= '0;
        dec_q  <= 1'b0;
      end else if (sync_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        if (sym_last) begin
          acc_q  <= '0;
          corr_q <= acc_next;
          dec_q  <= !acc_next[ACC_W-1] && (acc_next != '0);
        end else begin
          acc_q <= acc_next;
        end
      end
    end

    assign rx_corr_o[k*ACC_W +: ACC_W] = corr_q;
    assign rx_data_o[k]                = dec_q;
  end

endmodule

// File: tb/tb_cdma_gold_xcvr.sv
// Randomised scoreboard bench for cdma_gold_xcvr with a chip-level reference model.
module tb_cdma_gold_xcvr;

  localparam int N_LFSR = 5;
  localparam int N_CH   = 2;
  localparam int SF     = 31;
  localparam int ACC_W  = 6;
  localparam int TAP_A  = 'b11110;
  localparam int TAP_B  = 'b10010;

  typedef struct packed {
    logic [N_CH-1:0]       data;
    logic [N_CH*ACC_W-1:0] corr;
  } exp_t;

  logic                   clk_i;
  logic                   set_i;
  logic                   en_i;
  logic                   sync_i;
  logic [N_LFSR-1:0]      seed_a_i;
  logic [N_CH*N_LFSR-1:0] seed_b_i;
  logic [N_CH-1:0]        data_i;
  logic                   sym_strobe_o;
  logic [N_CH-1:0]        gold_o;
  logic [N_CH-1:0]        tx_chip_o;
  logic                   rx_chip_i;
  logic [N_CH-1:0]        rx_data_o;
  logic [N_CH*ACC_W-1:0]  rx_corr_o;
  logic                   rx_valid_o;
  logic                   seed_zero_o;

  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_pushed = 0;
  exp_t exp_q[$];

  int              m_a;
  int              m_b[N_CH];
  int              m_cnt;
  int              m_acc[N_CH];
  logic [N_CH-1:0] m_txd;

  cdma_gold_xcvr dut (
    .clk_i        (clk_i),
    .set_i        (set_i),
    .en_i         (en_i),
    .sync_i       (sync_i),
    .seed_a_i     (seed_a_i),
    .seed_b_i     (seed_b_i),
    .data_i       (data_i),
    .sym_strobe_o (sym_strobe_o),
    .gold_o       (gold_o),
    .tx_chip_o    (tx_chip_o),
    .rx_chip_i    (rx_chip_i),
    .rx_data_o    (rx_data_o),
    .rx_corr_o    (rx_corr_o),
    .rx_valid_o   (rx_valid_o),
    .seed_zero_o  (seed_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int fix_seed(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int lfsr_next(input int s, input int taps);
    int fb;
    fb = $countones(s & taps) % 2;
    return ((s << 1) | fb) & ((1 << N_LFSR) - 1);
  endfunction

  function automatic logic [N_CH-1:0] model_gold();
    logic [N_CH-1:0] g;
    for (int k = 0; k < N_CH; k++) begin
      g[k] = m_a[N_LFSR-1] ^ m_b[k][N_LFSR-1];
    end
    return g;
  endfunction

  function automatic logic model_seed_zero();
    logic z;
    z = (seed_a_i == '0);
    for (int k = 0; k < N_CH; k++) begin
      if (seed_b_i[k*N_LFSR +: N_LFSR] == '0) z = 1'b1;
    end
    return z;
  endfunction

  task automatic model_load();
    m_a   = fix_seed(int'(seed_a_i));
    for (int k = 0; k < N_CH; k++) begin
      m_b[k]   = fix_seed(int'(seed_b_i[k*N_LFSR +: N_LFSR]));
      m_acc[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock of stimulus: check combinational outputs, then advance the model.
  task automatic applyStimulus(input logic en, input logic sync,
                               input logic [N_CH-1:0] data, input logic noise);
    logic [N_CH-1:0] g;
    exp_t            e;
    logic            d;
    @(negedge clk_i);
    g         = model_gold();
    en_i      = en;
    sync_i    = sync;
    data_i    = data;
    rx_chip_i = m_txd[0] ^ g[0] ^ noise;
    #1;
    checkOutput("gold", 32'(gold_o), 32'(g));
    checkOutput("tx_chip", 32'(tx_chip_o), 32'(m_txd ^ g));
    checkOutput("sym_strobe", 32'(sym_strobe_o), 32'(en && (m_cnt == SF - 1)));
    checkOutput("seed_zero", 32'(seed_zero_o), 32'(model_seed_zero()));
    if (sync) begin
      model_load();
    end else if (en) begin
      for (int k = 0; k < N_CH; k++) begin
        d = rx_chip_i ^ g[k];
        m_acc[k] += d ? 1 : -1;
      end
      if (m_cnt == SF - 1) begin
        for (int k = 0; k < N_CH; k++) begin
          e.data[k] = (m_acc[k] > 0);
          e.corr[k*ACC_W +: ACC_W] = ACC_W'(m_acc[k]);
          m_acc[k] = 0;
        end
        exp_q.push_back(e);
        n_pushed++;
        m_txd = data;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_a = lfsr_next(m_a, TAP_A);
      for (int k = 0; k < N_CH; k++) m_b[k] = lfsr_next(m_b[k], TAP_B);
    end
  endtask

  // en_mode: 0 continuous, 1 one-in-three, 2 random; counts enabled chips only.
  task automatic runChips(input int nchips, input int en_mode, input logic rand_data,
                          input logic [N_CH-1:0] fixed_data, input int noise_pct);
    int   done;
    int   cyc;
    logic en;
    done = 0;
    cyc  = 0;
    while (done < nchips) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (cyc % 3 == 0);
        default: en = ($urandom_range(0, 9) < 7);
      endcase
      applyStimulus(en, 1'b0, rand_data ? N_CH'($urandom) : fixed_data,
                    ($urandom_range(0, 99) < noise_pct));
      if (en) done++;
      cyc++;
    end
  endtask

  // Asynchronous reset between clock edges, with immediate output checks.
  task automatic doReset(input logic [N_LFSR-1:0] sa, input logic [N_CH*N_LFSR-1:0] sb);
    @(negedge clk_i);
    #2;
    seed_a_i = sa;
    seed_b_i = sb;
    en_i     = 1'b0;
    sync_i   = 1'b0;
    set_i    = 1'b0;
    #1;
    model_load();
    m_txd = '0;
    checkOutput("rst_valid", 32'(rx_valid_o), 32'd0);
    checkOutput("rst_data", 32'(rx_data_o), 32'd0);
    checkOutput("rst_corr", 32'(rx_corr_o), 32'd0);
    checkOutput("rst_gold", 32'(gold_o), 32'(model_gold()));
    checkOutput("rst_tx_chip", 32'(tx_chip_o), 32'(model_gold()));
    checkOutput("rst_seed_zero", 32'(seed_zero_o), 32'(model_seed_zero()));
    @(negedge clk_i);
    set_i = 1'b1;
  endtask

  // Scoreboard monitor: every decision pulse must match the oldest expectation.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (rx_valid_o === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rx_data", 32'(rx_data_o), 32'(e.data));
        checkOutput("rx_corr", 32'(rx_corr_o), 32'(e.corr));
      end
    end
  end

  initial begin
    set_i     = 1'b0;
    en_i      = 1'b0;
    sync_i    = 1'b0;
    data_i    = '0;
    rx_chip_i = 1'b0;
    seed_a_i  = 5'b00000;
    seed_b_i  = {5'b10101, 5'b00001};
    m_txd     = '0;
    model_load();

    doReset(5'b00000, {5'b10101, 5'b00001});

    runChips(3 * SF, 0, 1'b0, 2'b01, 0);
    runChips(3 * SF, 0, 1'b0, 2'b00, 0);
    runChips(3 * SF, 1, 1'b1, 2'b00, 0);
    runChips(4 * SF, 2, 1'b1, 2'b00, 10);

    runChips(SF, 0, 1'b0, 2'b01, 0);
    runChips(17, 0, 1'b0, 2'b01, 0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0);
    runChips(2 * SF, 0, 1'b0, 2'b01, 0);

    seed_b_i = {5'b00000, 5'b01100};
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    runChips(2 * SF, 2, 1'b1, 2'b00, 5);

    runChips(10, 0, 1'b0, 2'b11, 0);
    doReset(N_LFSR'($urandom_range(1, 31)),
            {N_LFSR'($urandom_range(1, 31)), N_LFSR'($urandom_range(1, 31))});
    runChips(2 * SF, 0, 1'b0, 2'b11, 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_count", 32'(n_valid), 32'(n_pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
